stopwatch_ctrl: RTL and testbench

Parametrised run/stop/clear stopwatch core with up/down counting, combining button and UART byte commands into one control FSM. It drives a DIGITS-wide packed BCD value and status flags to the display controller. It replaces the fixed 4-digit, up-only counter/FSM pair. Debouncing and UART reception stay upstream; display multiplexing stays downstream.

---
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 84 ++++++++
 tb/tb_stopwatch_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: command inputs and display/status outputs of the stopwatch core
interface stopwatch_ctrl_if #(parameter int DIGITS = 4);
   logic [7:0]          i_rx_data;
   logic                i_rx_valid;
   logic                btn_run;
   logic                btn_clear;
   logic                btn_mode;
   logic                btn_lap;
   logic [4*DIGITS-1:0] o_bcd;
   logic                o_running;
   logic                o_down;
   logic                o_wrap;
   logic                o_lap;
   modport master (
      output i_rx_data, i_rx_valid, btn_run, btn_clear, btn_mode, btn_lap,
      input  o_bcd, o_running, o_down, o_wrap, o_lap
   );
   modport slave (
      input  i_rx_data, i_rx_valid, btn_run, btn_clear, btn_mode, btn_lap,
      output o_bcd, o_running, o_down, o_wrap, o_lap
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear BCD stopwatch with up/down mode; lap freeze built only when LAP_EN is defined
module stopwatch_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100,
   parameter int DIGITS  = 4
) (
   input logic             clk,
   input logic             reset,
   stopwatch_ctrl_if.slave bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   typedef enum logic {ST_STOP, ST_RUN} state_t;
   state_t              r_state, w_state_nxt;
   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] r_cnt, w_cnt_step, w_cnt_upd;
   logic                r_down, r_wrap, w_carry, w_tick;
   logic                w_run, w_clear, w_mode;
   assign w_run   = bus.btn_run   | (bus.i_rx_valid & (bus.i_rx_data == 8'h72 | bus.i_rx_data == 8'h52));
   assign w_clear = bus.btn_clear | (bus.i_rx_valid & (bus.i_rx_data == 8'h63 | bus.i_rx_data == 8'h43));
   assign w_mode  = bus.btn_mode  | (bus.i_rx_valid & (bus.i_rx_data == 8'h6d | bus.i_rx_data == 8'h4d));
   assign w_tick  = (r_state == ST_RUN) && (r_presc == PW'(DIV - 1));
   assign w_cnt_upd = w_tick ? w_cnt_step : r_cnt;
   // Next FSM state: clear forces STOP and outranks a simultaneous run toggle
   always_comb begin
      w_state_nxt = r_state;
      if (w_clear) w_state_nxt = ST_STOP;
      else if (w_run) w_state_nxt = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
   end
   // One decimal step of the counter; the carry/borrow out of the top digit marks a wrap
   always_comb begin
      w_cnt_step = r_cnt;
      w_carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_carry) begin
            w_cnt_step[4*i +: 4] = r_down ? ((r_cnt[4*i +: 4] == 4'd0) ? 4'd9 : r_cnt[4*i +: 4] - 4'd1)
                                          : ((r_cnt[4*i +: 4] == 4'd9) ? 4'd0 : r_cnt[4*i +: 4] + 4'd1);
            w_carry = r_down ? (r_cnt[4*i +: 4] == 4'd0) : (r_cnt[4*i +: 4] == 4'd9);
         end
      end
   end
   // State, prescaler (held while stopped so no partial tick is lost), live counter, direction and wrap pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_STOP;
         r_presc <= '0;
         r_cnt   <= '0;
         r_down  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_clear ? '0 : (r_state != ST_RUN) ? r_presc : w_tick ? '0 : r_presc + 1'b1;
         r_cnt   <= w_clear ? '0 : w_cnt_upd;
         r_wrap  <= !w_clear && w_tick && w_carry;
         r_down  <= r_down ^ w_mode;
      end
   end
   assign bus.o_running = (r_state == ST_RUN);
   assign bus.o_down    = r_down;
   assign bus.o_wrap    = r_wrap;
`ifdef LAP_EN
   logic                r_lap, w_lap, w_lap_nxt;
   logic [4*DIGITS-1:0] r_bcd;
   assign w_lap     = bus.btn_lap | (bus.i_rx_valid & (bus.i_rx_data == 8'h6c | bus.i_rx_data == 8'h4c));
   assign w_lap_nxt = !w_clear && (r_lap ^ (w_lap && r_state == ST_RUN));
   // Display register: keeps the shown value while frozen, otherwise follows the live count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lap <= 1'b0;
         r_bcd <= '0;
      end else begin
         r_lap <= w_lap_nxt;
         r_bcd <= w_lap_nxt ? r_bcd : (w_clear ? '0 : w_cnt_upd);
      end
   end
   assign bus.o_bcd = r_bcd;
   assign bus.o_lap = r_lap;
`else
   logic w_unused_lap;
   assign w_unused_lap = bus.btn_lap;
   assign bus.o_bcd = r_cnt;
   assign bus.o_lap = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, corner sequences and random stimulus against an integer stopwatch model
module tb_stopwatch_ctrl;
   localparam int DIV = 10;
   localparam int MOD = 10000;
   logic clk = 1'b0;
   logic reset = 1'b1;
   stopwatch_ctrl_if #(.DIGITS(4)) bus();
   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   int m_cnt, m_disp, m_presc;
   bit m_run, m_down, m_wrap, m_lap;
   typedef struct {
      logic [7:0]  rx;
      logic        rv, run, clr, mode;
      int          n;
      logic [15:0] bcd;
      logic        running, down;
   } vec_t;
   vec_t tbl[$];
   logic [7:0] cmds [10] = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h6d, 8'h4d, 8'h6c, 8'h4c, 8'h78, 8'h30};

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.i_rx_data = 8'h00;
      bus.i_rx_valid = 1'b0;
      bus.btn_run = 1'b0;
      bus.btn_clear = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_lap = 1'b0;
   endtask

   task automatic model_edge();
      logic [7:0] d = bus.i_rx_data;
      bit v = bus.i_rx_valid;
      bit clr, run, mode, tick;
`ifdef LAP_EN
      bit lap = bus.btn_lap || (v && (d == 8'h6c || d == 8'h4c));
`endif
      if (reset) begin
         m_cnt = 0; m_disp = 0; m_presc = 0;
         m_run = 0; m_down = 0; m_wrap = 0; m_lap = 0;
         return;
      end
      clr  = bus.btn_clear || (v && (d == 8'h63 || d == 8'h43));
      run  = bus.btn_run   || (v && (d == 8'h72 || d == 8'h52));
      mode = bus.btn_mode  || (v && (d == 8'h6d || d == 8'h4d));
      tick = m_run && (m_presc == DIV - 1);
      m_wrap = 0;
      if (clr) begin
         m_cnt = 0; m_presc = 0; m_run = 0; m_lap = 0;
      end else begin
         if (tick) begin
            m_wrap = m_down ? (m_cnt == 0) : (m_cnt == MOD - 1);
            m_cnt  = m_down ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
         end
         if (m_run) m_presc = tick ? 0 : m_presc + 1;
`ifdef LAP_EN
         if (lap && m_run) m_lap = !m_lap;
`endif
         if (run) m_run = !m_run;
      end
      if (mode) m_down = !m_down;
      if (!m_lap) m_disp = m_cnt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("step_bcd", 32'(bus.o_bcd), 32'(to_bcd(m_disp)));
      chk("step_running", 32'(bus.o_running), 32'(m_run));
      chk("step_down", 32'(bus.o_down), 32'(m_down));
      chk("step_wrap", 32'(bus.o_wrap), 32'(m_wrap));
      chk("step_lap", 32'(bus.o_lap), 32'(m_lap));
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      #1;
      step();
      step();
      chk("reset_bcd", 32'(bus.o_bcd), 32'h0);
      chk("reset_running", 32'(bus.o_running), 32'h0);
      reset = 1'b0;
      tbl.push_back('{8'h00, 0, 1, 0, 0,   1, 16'h0000, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,  10, 16'h0001, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,  90, 16'h0010, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0, 325, 16'h0042, 1, 0});
      tbl.push_back('{8'h72, 1, 0, 0, 0,   1, 16'h0042, 0, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,  20, 16'h0042, 0, 0});
      tbl.push_back('{8'h52, 1, 0, 0, 0,   1, 16'h0042, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   3, 16'h0042, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   1, 16'h0043, 1, 0});
      tbl.push_back('{8'h78, 1, 0, 0, 0,   1, 16'h0043, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0, 799, 16'h0123, 1, 0});
      tbl.push_back('{8'h63, 1, 1, 0, 0,   1, 16'h0000, 0, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,  15, 16'h0000, 0, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 1,   1, 16'h0000, 0, 1});
      tbl.push_back('{8'h00, 0, 1, 0, 0,   1, 16'h0000, 1, 1});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   9, 16'h0000, 1, 1});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   1, 16'h9999, 1, 1});
      tbl.push_back('{8'h00, 0, 0, 0, 1,   1, 16'h9999, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   9, 16'h0000, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 0,   9, 16'h0000, 1, 0});
      tbl.push_back('{8'h00, 0, 0, 0, 1,   1, 16'h0001, 1, 1});
      tbl.push_back('{8'h00, 0, 0, 0, 0,  10, 16'h0000, 1, 1});
      tbl.push_back('{8'h43, 1, 0, 0, 0,   1, 16'h0000, 0, 1});
      foreach (tbl[k]) begin
         bus.i_rx_data = tbl[k].rx;
         bus.i_rx_valid = tbl[k].rv;
         bus.btn_run = tbl[k].run;
         bus.btn_clear = tbl[k].clr;
         bus.btn_mode = tbl[k].mode;
         step();
         repeat (tbl[k].n - 1) step();
         chk($sformatf("tbl%0d_bcd", k), 32'(bus.o_bcd), 32'(tbl[k].bcd));
         chk($sformatf("tbl%0d_running", k), 32'(bus.o_running), 32'(tbl[k].running));
         chk($sformatf("tbl%0d_down", k), 32'(bus.o_down), 32'(tbl[k].down));
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.btn_run = 1'b1;
      step();
      repeat (570) step();
      bus.btn_mode = 1'b1;
      step();
      chk("pre_reset_bcd", 32'(bus.o_bcd), 32'h0057);
      chk("pre_reset_down", 32'(bus.o_down), 32'h1);
      reset = 1'b1;
      step();
      chk("midrun_reset", 32'({bus.o_bcd, bus.o_running, bus.o_down, bus.o_wrap, bus.o_lap}), 32'h0);
      reset = 1'b0;
      bus.btn_run = 1'b1;
      step();
      repeat (200) step();
      chk("lap_start_bcd", 32'(bus.o_bcd), 32'h0020);
      bus.btn_lap = 1'b1;
      step();
      repeat (48) step();
`ifdef LAP_EN
      chk("lap_frozen_bcd", 32'(bus.o_bcd), 32'h0020);
      chk("lap_frozen_flag", 32'(bus.o_lap), 32'h1);
`else
      chk("lap_live_bcd", 32'(bus.o_bcd), 32'h0024);
      chk("lap_live_flag", 32'(bus.o_lap), 32'h0);
`endif
      step();
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data = 8'h4c;
      step();
      chk("lap_release_bcd", 32'(bus.o_bcd), 32'h0025);
      chk("lap_release_flag", 32'(bus.o_lap), 32'h0);
      for (int k = 0; k < 4000; k++) begin
         reset = ($urandom_range(0, 499) == 0);
         bus.btn_run = ($urandom_range(0, 99) < 3);
         bus.btn_clear = ($urandom_range(0, 99) < 1);
         bus.btn_mode = ($urandom_range(0, 99) < 2);
         bus.btn_lap = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 9) == 0) begin
            int sel = $urandom_range(0, 11);
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data = (sel < 10) ? cmds[sel] : 8'($urandom);
         end
         step();
      end
      reset = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
